// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared screen and game-state encodings for the game flow controller
package game_pkg;

    typedef enum logic [1:0] {
        SCR_TITLE     = 2'd0,
        SCR_LEVEL     = 2'd1,
        SCR_GAME_OVER = 2'd2,
        SCR_VICTORY   = 2'd3
    } screen_t;

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_START     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_DEATH     = 3'd3,
        ST_CLEAR     = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_VICTORY   = 3'd6
    } game_state_t;

    // The frozen level stays visible during START/DEATH/CLEAR, so they share the level drawer.
    function automatic screen_t screen_of(input game_state_t st);
        case (st)
            ST_TITLE:     return SCR_TITLE;
            ST_GAME_OVER: return SCR_GAME_OVER;
            ST_VICTORY:   return SCR_VICTORY;
            default:      return SCR_LEVEL;
        endcase
    endfunction

endpackage

// File: rtl/button_press_detector.sv
// rtl/button_press_detector.sv - synchronises a raw button and emits one registered pulse per rising edge
module button_press_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    logic sync_meta;
    logic sync_out;
    logic sync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
            sync_prev <= 1'b0;
            press     <= 1'b0;
        end else begin
            sync_meta <= button;
            sync_out  <= sync_meta;
            sync_prev <= sync_out;
            press     <= sync_out & ~sync_prev;
        end
    end

endmodule

// File: rtl/game_screen_sequencer.sv
// rtl/game_screen_sequencer.sv - title/level/game-over/victory sequencing with lives and freeze hold
module game_screen_sequencer
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       jump_button,
    input  logic       win,
    input  logic       lose,
    output logic [1:0] screen,
    output logic       level_run,
    output logic       level_restart,
    output logic [2:0] lives,
    output logic [9:0] leds
);

    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);

    game_state_t state;
    game_state_t next_state;
    screen_t     screen_r;
    logic [7:0]  hold_cnt;
    logic        press;
    logic        holding;
    logic        hold_done;

    button_press_detector u_jump (
        .clk    (vga_clock),
        .rst_n  (reset),
        .button (jump_button),
        .press  (press)
    );

    assign holding   = (state == ST_DEATH) || (state == ST_CLEAR);
    assign hold_done = holding && frame_tick && (hold_cnt == HOLD_LAST);

    always_comb begin
        next_state = state;
        case (state)
            ST_TITLE:     if (press) next_state = ST_START;
            ST_START:     next_state = ST_PLAY;
            ST_PLAY: begin
                if (win)       next_state = ST_CLEAR;
                else if (lose) next_state = ST_DEATH;
            end
            ST_DEATH:     if (hold_done) next_state = (lives == 3'd0) ? ST_GAME_OVER : ST_START;
            ST_CLEAR:     if (hold_done) next_state = ST_VICTORY;
            ST_GAME_OVER: if (press) next_state = ST_TITLE;
            ST_VICTORY:   if (press) next_state = ST_TITLE;
            default:      next_state = ST_TITLE;
        endcase
    end

    // Outputs are decoded from next_state so they are registered yet aligned with the state register.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_TITLE;
            screen_r      <= SCR_TITLE;
            level_run     <= 1'b0;
            level_restart <= 1'b0;
            lives         <= LIVES_INIT;
            hold_cnt      <= 8'd0;
        end else begin
            state         <= next_state;
            screen_r      <= screen_of(next_state);
            level_run     <= (next_state == ST_PLAY);
            level_restart <= (next_state == ST_START);

            if (state == ST_TITLE && press)
                lives <= LIVES_INIT;
            else if (state == ST_PLAY && !win && lose && lives != 3'd0)
                lives <= lives - 3'd1;

            if (state == ST_PLAY && (win || lose))
                hold_cnt <= 8'd0;
            else if (holding && frame_tick)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end

    assign screen = screen_r;
    assign leds   = {state, 4'd0, lives};

endmodule
